// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a trial code into a magnitude
// comparator, one decision per cycle, and reports the code matching the comparator's A side.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_agb,
    input  logic             cmp_aeb,
    input  logic             cmp_alb,
    output logic [WIDTH-1:0] trial_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0]  TOP_IDX = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0]  IDX_ONE = IDXW'(1);
    localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {
        IDLE,
        SEARCH
    } stateType;

    stateType         stateReg, stateNext;
    logic [WIDTH-1:0] trialReg, trialNext;
    logic [IDXW-1:0]  bitIdxReg, bitIdxNext;
    logic [WIDTH-1:0] resultReg, resultNext;
    logic             doneReg, doneNext;
    logic             errReg, errNext;

    logic [WIDTH-1:0] bitMask;
    logic [WIDTH-1:0] nextMask;
    logic [WIDTH-1:0] keptCode;
    logic             keepBit;
    logic             flagsOneHot;

    // Only a clean A>B keeps the bit; every other non-equal pattern clears it.
    assign keepBit     = cmp_agb & ~cmp_alb & ~cmp_aeb;
    assign flagsOneHot = (cmp_agb ^ cmp_alb ^ cmp_aeb) & ~(cmp_agb & cmp_alb & cmp_aeb);
    assign nextMask    = bitMask >> 1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bitMask[gi]  = (bitIdxReg == IDXW'(gi));
            assign keptCode[gi] = bitMask[gi] ? keepBit : trialReg[gi];
        end
    endgenerate

    always_comb begin
        stateNext  = stateReg;
        trialNext  = trialReg;
        bitIdxNext = bitIdxReg;
        resultNext = resultReg;
        doneNext   = 1'b0;
        errNext    = errReg;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    trialNext  = TOP_BIT;
                    bitIdxNext = TOP_IDX;
                    errNext    = 1'b0;
                    stateNext  = SEARCH;
                end
            end
            SEARCH: begin
                if (!flagsOneHot) begin
                    errNext = 1'b1;
                end
                if (cmp_aeb || (bitIdxReg == '0)) begin
                    resultNext = cmp_aeb ? trialReg : keptCode;
                    doneNext   = 1'b1;
                    trialNext  = '0;
                    stateNext  = IDLE;
                end else begin
                    trialNext  = keptCode | nextMask;
                    bitIdxNext = bitIdxReg - IDX_ONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= IDLE;
            trialReg  <= '0;
            bitIdxReg <= TOP_IDX;
            resultReg <= '0;
            doneReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            trialReg  <= trialNext;
            bitIdxReg <= bitIdxNext;
            resultReg <= resultNext;
            doneReg   <= doneNext;
            errReg    <= errNext;
        end
    end

    assign trial_b = trialReg;
    assign busy    = (stateReg == SEARCH);
    assign done    = doneReg;
    assign result  = resultReg;
    assign err     = errReg;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a behavioural comparator closes the loop, and a
// binary-search reference model predicts trial codes, result, latency and err.
module tb_sar_search_ctrl;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cmp_agb, cmp_aeb, cmp_alb;
    logic [W-1:0] trial_b;
    logic         busy, done, err;
    logic [W-1:0] result;

    logic [W-1:0] target;
    logic         forceEn;
    logic [2:0]   forceFlags;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] expTrials[$];
    logic [W-1:0] expResult;
    int           expLat;
    logic         expErr;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_agb(cmp_agb),
        .cmp_aeb(cmp_aeb),
        .cmp_alb(cmp_alb),
        .trial_b(trial_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator with A = target, B = trial_b; flags can be overridden as {agb, aeb, alb}.
    always_comb begin
        if (forceEn) begin
            {cmp_agb, cmp_aeb, cmp_alb} = forceFlags;
        end else begin
            cmp_agb = (target > trial_b);
            cmp_aeb = (target == trial_b);
            cmp_alb = (target < trial_b);
        end
    end

    task automatic check(input string tag, input bit ok, input int obs, input int exp);
        tests++;
        if (!ok) begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Plain binary search over the target; a forced first decision clears the MSB.
    task automatic buildModel(input logic [W-1:0] t, input bit forceFirst);
        logic [W-1:0] code;
        logic [W-1:0] trial;
        expTrials.delete();
        code      = '0;
        expResult = '0;
        expLat    = W;
        expErr    = forceFirst;
        for (int i = W - 1; i >= 0; i--) begin
            trial = code | W'(1 << i);
            expTrials.push_back(trial);
            if (forceFirst && i == W - 1) continue;
            if (trial == t) begin
                expResult = trial;
                expLat    = W - i;
                return;
            end
            if (trial < t) code = trial;
        end
        expResult = code;
    endtask

    task automatic acceptStart(input logic [W-1:0] t, input bit holdStart);
        target = t;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (!holdStart) start = 1'b0;
        check("accept_busy", busy === 1'b1, busy, 1);
        check("accept_trial", trial_b === W'(8), trial_b, 8);
        check("accept_done", done === 1'b0, done, 0);
        check("accept_err", err === 1'b0, err, 0);
    endtask

    task automatic finishSearch(input logic [W-1:0] t, input bit forceFirst);
        int lat;
        lat = 0;
        buildModel(t, forceFirst);
        for (int n = 1; n <= W + 2; n++) begin
            if (n <= expTrials.size()) begin
                check("trial_code", trial_b === expTrials[n-1], trial_b, expTrials[n-1]);
            end
            if (forceFirst && n == 1) begin
                forceFlags = 3'b000;
                forceEn    = 1'b1;
            end
            @(posedge clk);
            #1;
            forceEn = 1'b0;
            lat     = n;
            if (done) break;
        end
        check("done_seen", done === 1'b1, done, 1);
        check("latency", lat === expLat, lat, expLat);
        check("result", result === expResult, result, expResult);
        check("err_at_done", err === expErr, err, expErr);
        check("busy_at_done", busy === 1'b0, busy, 0);
        check("trial_at_done", trial_b === W'(0), trial_b, 0);
        $display("[TB] target=%0d force=%0d result=%0d err=%0d latency=%0d", t, forceFirst, result, err, lat);
    endtask

    task automatic idleHold(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            check("idle_done", done === 1'b0, done, 0);
            check("idle_busy", busy === 1'b0, busy, 0);
            check("idle_result", result === expResult, result, expResult);
            check("idle_err", err === expErr, err, expErr);
        end
    endtask

    task automatic runFull(input logic [W-1:0] t, input bit forceFirst);
        acceptStart(t, 1'b0);
        finishSearch(t, forceFirst);
        idleHold(1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        target     = '0;
        forceEn    = 1'b0;
        forceFlags = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_trial", trial_b === W'(0), trial_b, 0);
        check("reset_busy", busy === 1'b0, busy, 0);
        check("reset_done", done === 1'b0, done, 0);
        check("reset_result", result === W'(0), result, 0);
        check("reset_err", err === 1'b0, err, 0);
        rst = 1'b0;

        // Reset in the middle of a search abandons it.
        acceptStart(4'd9, 1'b0);
        @(posedge clk);
        #1;
        check("mid_trial", trial_b === W'(12), trial_b, 12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_trial", trial_b === W'(0), trial_b, 0);
        check("rst_busy", busy === 1'b0, busy, 0);
        check("rst_done", done === 1'b0, done, 0);
        check("rst_result", result === W'(0), result, 0);
        $display("[TB] reset mid-search: trial=%0d busy=%0d result=%0d", trial_b, busy, result);
        runFull(4'd9, 1'b0);

        runFull(4'd12, 1'b0);
        runFull(4'd0, 1'b0);
        runFull(4'd15, 1'b0);
        runFull(4'd9, 1'b0);

        // Non-one-hot flags on the first decision: err set and held through done.
        runFull(4'd5, 1'b1);
        idleHold(2);
        runFull(4'd6, 1'b0);

        // Back-to-back: start held through the search, next accepted in the done cycle.
        acceptStart(4'd5, 1'b1);
        finishSearch(4'd5, 1'b0);
        acceptStart(4'd10, 1'b0);
        finishSearch(4'd10, 1'b0);
        idleHold(1);

        for (int t = 0; t < 16; t++) begin
            runFull(W'(t), 1'b0);
        end

        for (int r = 0; r < 24; r++) begin
            runFull(W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
